// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI image-link types and default constants
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    SHIFT,
    HOLD,
    FINISH
  } spi_tx_state_t;

  localparam int SPI_CLK_DIV     = 4;
  localparam int SPI_FRAME_BYTES = 113;
  localparam int SPI_CS_GAP      = 4;

endpackage

// File: rtl/spi_image_sender_if.sv
// rtl/spi_image_sender_if.sv - byte stream feeding the SPI image sender
interface spi_image_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter emitting SCLK rise/fall strobes
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current SCLK level decides which edge the wrap produces.
  assign rise_o = wrap && !level_i;
  assign fall_o = wrap &&  level_i;

endmodule

// File: rtl/spi_image_sender.sv
// rtl/spi_image_sender.sv - SPI mode-0 transmitter sending one framed image per start
module spi_image_sender
  import spi_pkg::*;
#(
  parameter int CLK_DIV     = SPI_CLK_DIV,
  parameter int FRAME_BYTES = SPI_FRAME_BYTES,
  parameter int CS_GAP      = SPI_CS_GAP
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  spi_image_sender_if.slave                  tx,
  output logic                               SCLK,
  output logic                               COPI,
  output logic                               spi_cs_n,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count
);

  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam int GW  = $clog2(CS_GAP + 1);

  spi_tx_state_t  state_q, state_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sr_q, sr_d;
  logic           sclk_q, sclk_d;
  logic           copi_q, copi_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic           rise, fall;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == SHIFT),
    .level_i (sclk_q),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    sclk_d      = sclk_q;
    copi_d      = copi_q;
    cnt_d       = cnt_q;
    tx.tx_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = '0;
          gap_d   = '0;
        end
      end
      SETUP: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          state_d = LOAD;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      LOAD: begin
        tx.tx_ready = 1'b1;
        if (tx.tx_valid) begin
          sr_d    = tx.tx_data;
          copi_d  = tx.tx_data[7];
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          sclk_d = 1'b1;
        end
        if (fall) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            // COPI keeps bit 0 so it holds steady through any LOAD stall.
            cnt_d = (cnt_q == BCW'(FRAME_BYTES)) ? cnt_q : cnt_q + 1'b1;
            if (cnt_q < BCW'(FRAME_BYTES - 1)) begin
              state_d = LOAD;
            end else begin
              state_d = HOLD;
              gap_d   = '0;
            end
          end else begin
            sr_d   = {sr_q[6:0], 1'b0};
            copi_d = sr_q[6];
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          state_d = FINISH;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign spi_cs_n   = !((state_q == SETUP) || (state_q == LOAD) ||
                        (state_q == SHIFT) || (state_q == HOLD));
  assign SCLK       = sclk_q;
  assign COPI       = copi_q;
  assign byte_count = cnt_q;

endmodule

// File: doc/spi_image_sender.md
SPI_IMAGE_SENDER -- requirements
Module: spi_image_sender

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk cycles (legal values are 2 and above).
REQ-002 The module SHALL have parameter FRAME_BYTES, default 113, giving the bytes per chip-select frame (113 bytes hold one 30x30 binary image, padded).
REQ-003 The module SHALL have parameter CS_GAP, default 4, giving the clk cycles from CS assert to the first SCLK edge, and from the last SCLK edge to CS deassert.
REQ-004 clk  input  1  single system clock, all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame; it is ignored while busy=1.
REQ-007 tx_data  input  8  byte to transmit, MSB first.
REQ-008 tx_valid  input  1  tx_data is valid.
REQ-009 tx_ready  output  1  the byte is consumed on any cycle where tx_valid and tx_ready are both 1.
REQ-010 SCLK  output  1  SPI clock, mode 0 (idles low).
REQ-011 COPI  output  1  serial data, changes only while SCLK is low.
REQ-012 spi_cs_n  output  1  active-low chip select, low for the whole frame.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  one-cycle pulse when the frame completes.
REQ-015 byte_count  output  $clog2(FRAME_BYTES+1)  number of bytes fully shifted out in the current or last frame.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, LOAD, SHIFT, HOLD and FINISH.
REQ-017 IDLE -> SETUP on start; on that transition, spi_cs_n goes low, byte_count clears and busy goes high on the next cycle.
REQ-018 SETUP SHALL wait CS_GAP cycles with SCLK=0, then go to LOAD.
REQ-019 In LOAD, tx_ready=1 and SCLK=0; on a handshake, the byte is latched into an 8-bit shift register, COPI takes bit 7, and the FSM goes to SHIFT.
REQ-020 If tx_valid=0 in LOAD, the FSM SHALL stall in LOAD indefinitely, with spi_cs_n held low, SCLK held low and COPI holding its last value.
REQ-021 In SHIFT, each bit SHALL be CLK_DIV cycles with SCLK low followed by CLK_DIV cycles with SCLK high, so one byte takes 16*CLK_DIV cycles.
REQ-022 The shift register SHALL shift left, and COPI update to the next bit, in the same cycle SCLK falls.
REQ-023 After the 8th high phase, SCLK SHALL return low and byte_count SHALL increment.
REQ-024 At the end of each byte, the FSM SHALL go to LOAD if byte_count < FRAME_BYTES, else to HOLD.
REQ-025 HOLD SHALL wait CS_GAP cycles with SCLK=0, then raise spi_cs_n and go to FINISH.
REQ-026 FINISH SHALL pulse done for exactly 1 cycle with busy still 1, then go to IDLE with busy=0.
REQ-027 tx_ready SHALL be 0 in every state except LOAD.
REQ-028 In every state except SHIFT, SCLK SHALL be 0.
REQ-029 A start arriving in FINISH SHALL be ignored, and no start SHALL be queued.
REQ-030 The half-period counter SHALL wrap from CLK_DIV-1 to 0.
REQ-031 byte_count SHALL saturate at FRAME_BYTES and hold its value in IDLE until the next start.

Reset
REQ-032 On rst=1 at a clock edge, the module SHALL enter IDLE and set SCLK=0, COPI=0, spi_cs_n=1, tx_ready=0, busy=0, done=0 and byte_count=0.
REQ-033 Reset mid-frame SHALL abort the frame on the next edge, with no done pulse, and any partial byte is lost.
REQ-034 rst SHALL take priority over start.

Structure
REQ-035 Package spi_pkg SHALL hold the state enum spi_tx_state_t and the default constants SPI_CLK_DIV, SPI_FRAME_BYTES and SPI_CS_GAP; these are shared with the receive side.
REQ-036 Sub-module spi_sclk_gen SHALL provide the half-period counter and emit rise/fall tick strobes; all other logic SHALL stay in spi_image_sender.

Verification
REQ-037 Scenario: CLK_DIV=2, FRAME_BYTES=2, tx_valid held 1 with bytes 0xA5 then 0x3C -> a reference SPI mode-0 sampler captures A5 3C, there are exactly 16 SCLK rises, spi_cs_n is low for 2*CS_GAP + 2*32 + LOAD cycles, and done pulses once.
REQ-038 Scenario: drop tx_valid for 10 cycles between bytes -> SCLK stays 0 and spi_cs_n stays 0 during the stall, and the data is still correct.
REQ-039 Scenario: pulse start while busy, and again during FINISH -> exactly one frame is sent.
REQ-040 Scenario: assert rst during bit 4 of byte 1 -> on the next edge spi_cs_n=1, SCLK=0 and busy=0; done never pulses; a new start then sends a full clean frame.
REQ-041 Scenario: default parameters, 113 bytes of 0xFF -> byte_count reaches 113 and saturates, there are 904 SCLK rises, COPI never changes while SCLK is high, and done pulses once.
